// File: rtl/bus_pkg.sv
// Shared types for the pin-side bus cycle unit: machine-cycle codes, T-states,
// status encodings and small decode helpers.
package bus_pkg;

  typedef enum logic [2:0] {
    McFetch = 3'b000,
    McMemRd = 3'b001,
    McMemWr = 3'b010,
    McIoRd  = 3'b011,
    McIoWr  = 3'b100
  } mc_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StTw,
    StT3,
    StT4
  } t_state_e;

  // {s1, s0}
  localparam logic [1:0] StatusFetch = 2'b11;
  localparam logic [1:0] StatusRead  = 2'b10;
  localparam logic [1:0] StatusWrite = 2'b01;

  function automatic logic mc_valid(input logic [2:0] t);
    return t <= 3'b100;
  endfunction

  function automatic logic mc_is_write(input logic [2:0] t);
    return (t == McMemWr) || (t == McIoWr);
  endfunction

  function automatic logic mc_is_io(input logic [2:0] t);
    return (t == McIoRd) || (t == McIoWr);
  endfunction

  function automatic logic [1:0] mc_status(input logic [2:0] t);
    logic [1:0] s;
    s = StatusRead;
    if (t == McFetch) s = StatusFetch;
    else if (mc_is_write(t)) s = StatusWrite;
    return s;
  endfunction

endpackage

// File: rtl/bus_cycle_unit_if.sv
// Sequencer request channel plus 8085-style multiplexed pin bus.
// master = sequencer/pin environment, slave = bus_cycle_unit.
interface bus_cycle_unit_if;
  logic        req;
  logic        req_rdy;
  logic [2:0]  mc_type;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        iom_n;
  logic        s1;
  logic        s0;
  logic [7:0]  rdata;
  logic        done;
  logic        bus_err;

  modport master (
    output req, mc_type, addr, wdata, ready, ad_in,
    input  req_rdy, ad_out, ad_oe, a_hi, ale, rd_n, wr_n, iom_n, s1, s0, rdata, done, bus_err
  );

  modport slave (
    input  req, mc_type, addr, wdata, ready, ad_in,
    output req_rdy, ad_out, ad_oe, a_hi, ale, rd_n, wr_n, iom_n, s1, s0, rdata, done, bus_err
  );
endinterface

// File: rtl/bus_cycle_unit.sv
// Sequences one machine cycle at a time through T1/T2/TW/T3(/T4) on the
// multiplexed bus and returns read data to the decoder.
module bus_cycle_unit
  import bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  bus_cycle_unit_if.slave   bus
);

  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast =
    WaitW'((MAX_WAIT > 0) ? MAX_WAIT - 32'd1 : 32'd0);

  t_state_e         state_q, state_d;
  mc_type_e         type_q, type_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             bus_err_q, bus_err_d;
  logic [7:0]       a_hi_q, a_hi_d;
  logic             iom_n_q, iom_n_d;
  logic [1:0]       status_q, status_d;

  logic       is_write, is_fetch, last_state, accept;
  logic       ale, ad_oe, rd_n, wr_n, done;
  logic [7:0] ad_out;

  assign is_write   = mc_is_write(type_q);
  assign is_fetch   = (type_q == McFetch);
  // Final T-state of a cycle also accepts, giving back-to-back cycles.
  assign last_state = (state_q == StIdle) || (state_q == StT4) ||
                      ((state_q == StT3) && !is_fetch);
  assign accept     = bus.req && last_state && mc_valid(bus.mc_type);

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    a_hi_d    = a_hi_q;
    iom_n_d   = iom_n_q;
    status_d  = status_q;

    unique case (state_q)
      StT1: state_d = StT2;
      StT2: begin
        wait_d  = '0;
        state_d = bus.ready ? StT3 : StTw;
      end
      StTw: begin
        if (bus.ready) begin
          state_d = StT3;
        end else if ((MAX_WAIT != 0) && (wait_q == WaitLast)) begin
          state_d   = StIdle;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StT3: begin
        if (!is_write) rdata_d = bus.ad_in;
        state_d = is_fetch ? StT4 : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d  = StT1;
      type_d   = mc_type_e'(bus.mc_type);
      addr_d   = bus.addr;
      wdata_d  = bus.wdata;
      a_hi_d   = bus.addr[15:8];
      iom_n_d  = mc_is_io(bus.mc_type);
      status_d = mc_status(bus.mc_type);
    end
  end

  always_comb begin
    ale    = 1'b0;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    done   = 1'b0;
    unique case (state_q)
      StT1: begin
        ale    = 1'b1;
        ad_oe  = 1'b1;
        ad_out = addr_q[7:0];
      end
      StT2, StTw, StT3: begin
        if (is_write) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
          wr_n   = 1'b0;
        end else begin
          rd_n = 1'b0;
        end
        done = (state_q == StT3) && !is_fetch;
      end
      StT4:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      type_q    <= McFetch;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_q    <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      a_hi_q    <= '0;
      iom_n_q   <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      a_hi_q    <= a_hi_d;
      iom_n_q   <= iom_n_d;
      status_q  <= status_d;
    end
  end

  assign bus.req_rdy = last_state;
  assign bus.ale     = ale;
  assign bus.ad_oe   = ad_oe;
  assign bus.ad_out  = ad_out;
  assign bus.rd_n    = rd_n;
  assign bus.wr_n    = wr_n;
  assign bus.done    = done;
  assign bus.a_hi    = a_hi_q;
  assign bus.iom_n   = iom_n_q;
  assign bus.s1      = status_q[1];
  assign bus.s0      = status_q[0];
  assign bus.rdata   = rdata_q;
  assign bus.bus_err = bus_err_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Directed bench for bus_cycle_unit (MAX_WAIT=3): inputs driven 1 time unit
// after each rising edge, outputs checked on the falling edge.
module tb_bus_cycle_unit;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  bus_cycle_unit_if bus_if ();

  bus_cycle_unit #(
    .MAX_WAIT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.req     = 1'b0;
    bus_if.mc_type = 3'b000;
    bus_if.addr    = 16'h0000;
    bus_if.wdata   = 8'h00;
    bus_if.ready   = 1'b1;
    bus_if.ad_in   = 8'h00;
    tick();
    tick();
    smp();
    chk("rst_ale", bus_if.ale, 1'b0);
    chk("rst_rd_n", bus_if.rd_n, 1'b1);
    chk("rst_wr_n", bus_if.wr_n, 1'b1);
    chk("rst_ad_oe", bus_if.ad_oe, 1'b0);
    chk("rst_ad_out", bus_if.ad_out, 8'h00);
    chk("rst_a_hi", bus_if.a_hi, 8'h00);
    chk("rst_iom_s", {bus_if.iom_n, bus_if.s1, bus_if.s0}, 3'b000);
    chk("rst_rdata", bus_if.rdata, 8'h00);
    chk("rst_done_err", {bus_if.done, bus_if.bus_err}, 2'b00);
    chk("rst_req_rdy", bus_if.req_rdy, 1'b1);
    tick();
    reset = 1'b0;

    // FETCH 0x1234
    tick();
    bus_if.req = 1'b1; bus_if.mc_type = 3'b000; bus_if.addr = 16'h1234;
    tick();                                   // cycle 1: T1
    bus_if.req = 1'b0;
    smp();
    chk("f_t1_ale", bus_if.ale, 1'b1);
    chk("f_t1_ad", {bus_if.ad_oe, bus_if.ad_out}, 9'h134);
    chk("f_t1_a_hi", bus_if.a_hi, 8'h12);
    chk("f_t1_status", {bus_if.iom_n, bus_if.s1, bus_if.s0}, 3'b011);
    chk("f_t1_rd_n", bus_if.rd_n, 1'b1);
    tick();                                   // cycle 2: T2
    smp();
    chk("f_t2_strobes", {bus_if.ale, bus_if.ad_oe, bus_if.rd_n, bus_if.wr_n}, 4'b0001);
    tick();                                   // cycle 3: T3
    bus_if.ad_in = 8'h7E;
    smp();
    chk("f_t3_rd_n_done", {bus_if.rd_n, bus_if.done}, 2'b00);
    tick();                                   // cycle 4: T4
    bus_if.ad_in = 8'h00;
    smp();
    chk("f_t4_done", bus_if.done, 1'b1);
    chk("f_t4_rd_n", bus_if.rd_n, 1'b1);
    chk("f_t4_rdata", bus_if.rdata, 8'h7E);
    chk("f_t4_req_rdy", bus_if.req_rdy, 1'b1);
    tick();                                   // idle
    smp();
    chk("f_idle_done", bus_if.done, 1'b0);
    chk("f_idle_hold", {bus_if.a_hi, bus_if.s1, bus_if.s0}, 10'h04B);

    // MEM_WR 0x2000 <= A5
    bus_if.req = 1'b1; bus_if.mc_type = 3'b010; bus_if.addr = 16'h2000; bus_if.wdata = 8'hA5;
    tick();                                   // cycle 1: T1
    bus_if.req = 1'b0;
    smp();
    chk("w_t1_ad", {bus_if.ale, bus_if.ad_oe, bus_if.ad_out}, 10'h300);
    chk("w_t1_status", {bus_if.iom_n, bus_if.s1, bus_if.s0}, 3'b001);
    tick();                                   // cycle 2: T2
    smp();
    chk("w_t2_strobes", {bus_if.rd_n, bus_if.wr_n}, 2'b10);
    chk("w_t2_ad", {bus_if.ad_oe, bus_if.ad_out}, 9'h1A5);
    tick();                                   // cycle 3: T3
    smp();
    chk("w_t3_wr_n_done", {bus_if.wr_n, bus_if.done}, 2'b01);
    chk("w_t3_ad", {bus_if.ad_oe, bus_if.ad_out}, 9'h1A5);
    tick();                                   // idle
    smp();
    chk("w_idle", {bus_if.wr_n, bus_if.ad_oe, bus_if.done}, 3'b100);

    // IO_RD 0x0055 with two wait states
    bus_if.req = 1'b1; bus_if.mc_type = 3'b011; bus_if.addr = 16'h0055;
    tick();                                   // cycle 1: T1
    bus_if.req = 1'b0; bus_if.ready = 1'b0;
    smp();
    chk("io_t1_status", {bus_if.iom_n, bus_if.s1, bus_if.s0}, 3'b110);
    tick();                                   // cycle 2: T2
    smp();
    chk("io_t2_rd_n", bus_if.rd_n, 1'b0);
    tick();                                   // cycle 3: TW1
    smp();
    chk("io_tw1", {bus_if.rd_n, bus_if.done}, 2'b00);
    tick();                                   // cycle 4: TW2
    bus_if.ready = 1'b1;
    smp();
    chk("io_tw2", {bus_if.rd_n, bus_if.done, bus_if.bus_err}, 3'b000);
    tick();                                   // cycle 5: T3
    bus_if.ad_in = 8'hC3;
    smp();
    chk("io_t3_done", {bus_if.rd_n, bus_if.done}, 2'b01);
    chk("io_t3_rdata_old", bus_if.rdata, 8'h7E);
    tick();                                   // idle
    bus_if.ad_in = 8'h00;
    smp();
    chk("io_rdata", bus_if.rdata, 8'hC3);
    chk("io_idle", {bus_if.rd_n, bus_if.done, bus_if.iom_n}, 3'b101);

    // MEM_RD 0x3000 with READY stuck low: abort after three TW states
    bus_if.req = 1'b1; bus_if.mc_type = 3'b001; bus_if.addr = 16'h3000;
    bus_if.ready = 1'b0;
    tick();                                   // T1
    bus_if.req = 1'b0;
    tick();                                   // T2
    tick();                                   // TW1
    tick();                                   // TW2
    smp();
    chk("to_tw2", {bus_if.rd_n, bus_if.bus_err}, 2'b00);
    tick();                                   // TW3
    smp();
    chk("to_tw3", {bus_if.rd_n, bus_if.bus_err, bus_if.done}, 3'b000);
    tick();                                   // aborted -> idle
    smp();
    chk("to_err", {bus_if.bus_err, bus_if.rd_n, bus_if.done, bus_if.req_rdy}, 4'b1101);
    tick();
    bus_if.ready = 1'b1;
    smp();
    chk("to_err_pulse", {bus_if.bus_err, bus_if.rdata}, 9'h0C3);

    // Back-to-back MEM_RD 0x4000 then MEM_WR 0x5011 <= 5A
    bus_if.req = 1'b1; bus_if.mc_type = 3'b001; bus_if.addr = 16'h4000;
    tick();                                   // cycle 1: T1 (read)
    bus_if.mc_type = 3'b010; bus_if.addr = 16'h5011; bus_if.wdata = 8'h5A;
    smp();
    chk("bb_c1", {bus_if.ale, bus_if.req_rdy}, 2'b10);
    tick();                                   // cycle 2: T2
    smp();
    chk("bb_c2", {bus_if.ale, bus_if.req_rdy, bus_if.rd_n}, 3'b000);
    tick();                                   // cycle 3: T3
    bus_if.ad_in = 8'h96;
    smp();
    chk("bb_c3", {bus_if.req_rdy, bus_if.done, bus_if.ale}, 3'b110);
    tick();                                   // cycle 4: T1 (write)
    bus_if.req = 1'b0; bus_if.ad_in = 8'h00;
    smp();
    chk("bb_c4_ale", {bus_if.ale, bus_if.rd_n, bus_if.ad_out}, 10'h311);
    chk("bb_c4_a_hi", {bus_if.a_hi, bus_if.s1, bus_if.s0}, 10'h141);
    chk("bb_c4_rdata", bus_if.rdata, 8'h96);
    tick();                                   // cycle 5: T2
    smp();
    chk("bb_c5", {bus_if.wr_n, bus_if.ad_out}, 9'h05A);
    tick();                                   // cycle 6: T3
    smp();
    chk("bb_c6", bus_if.done, 1'b1);
    tick();                                   // idle

    // IO_WR 0x0077 <= 3C, reset during TW
    bus_if.req = 1'b1; bus_if.mc_type = 3'b100; bus_if.addr = 16'h0077; bus_if.wdata = 8'h3C;
    tick();                                   // T1
    bus_if.req = 1'b0; bus_if.ready = 1'b0;
    tick();                                   // T2
    tick();                                   // TW
    reset = 1'b1;
    smp();
    chk("rw_tw", {bus_if.wr_n, bus_if.ad_oe, bus_if.ad_out}, 10'h13C);
    tick();                                   // reset taken -> idle
    reset = 1'b0; bus_if.ready = 1'b1;
    smp();
    chk("rw_after", {bus_if.wr_n, bus_if.ad_oe, bus_if.done, bus_if.req_rdy}, 4'b1001);
    chk("rw_rdata", bus_if.rdata, 8'h00);
    tick();
    smp();
    chk("rw_no_done", {bus_if.done, bus_if.ale}, 2'b00);

    // Reserved mc_type is ignored
    bus_if.req = 1'b1; bus_if.mc_type = 3'b111; bus_if.addr = 16'hBEEF;
    tick();
    smp();
    chk("rsv_c1", {bus_if.ale, bus_if.req_rdy, bus_if.ad_oe}, 3'b010);
    tick();
    bus_if.req = 1'b0;
    smp();
    chk("rsv_c2", {bus_if.ale, bus_if.rd_n, bus_if.wr_n, bus_if.a_hi}, 11'h300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_cycle_unit.md
Name: bus_cycle_unit

Overview:
- Pin-side bus interface that sits directly downstream of the instruction decoder/sequencer.
- Accepts one machine-cycle request at a time: opcode fetch, memory read/write, or I/O read/write.
- Sequences T1/T2/TW/T3(/T4) on the 8085-style multiplexed bus: ALE, RDn, WRn, IOMn, S1/S0, AD7..0, A15..8.
- Returns read data, which the decoder uses as its next instruction byte or operand, and signals cycle completion.

Parameters:
- MAX_WAIT, 0, maximum TW states per cycle; 0 = unlimited, otherwise exceeding it aborts the cycle with bus_err.

Ports:
- clk  input  1  system clock, one T-state per cycle.
- reset  input  1  reset, synchronous, active-high.
- req  input  1  start machine cycle; sampled only when req_rdy=1.
- req_rdy  output  1  unit can accept a request this cycle.
- mc_type  input  3  cycle type, encoded per bus_pkg.
- addr  input  16  cycle address, latched on acceptance.
- wdata  input  8  write data, latched on acceptance.
- ready  input  1  external READY pin; 0 inserts wait states.
- ad_in  input  8  AD7..0 pin input.
- ad_out  output  8  AD7..0 pin output value.
- ad_oe  output  1  AD7..0 output enable.
- a_hi  output  8  A15..8 pins.
- ale  output  1  address latch enable.
- rd_n  output  1  read strobe, active-low.
- wr_n  output  1  write strobe, active-low.
- iom_n  output  1  1 = I/O cycle.
- s1, s0  output  1 each  cycle status.
- rdata  output  8  captured read data.
- done  output  1  one-cycle pulse on the final T-state of every cycle.
- bus_err  output  1  one-cycle pulse when a cycle is aborted on wait timeout.

Behaviour:
- Reset: state IDLE. ale=0, rd_n=1, wr_n=1, ad_oe=0, ad_out=0, a_hi=0, iom_n=0, s1=0, s0=0, rdata=0, done=0, bus_err=0, req_rdy=1.
- A reset asserted mid-cycle aborts immediately: strobes return high, no done pulse is generated, and rdata keeps its reset value.
- States: IDLE, T1, T2, TW, T3, T4.
- Acceptance: a request is accepted when req & req_rdy. req_rdy=1 in IDLE and on the final state of a cycle (T3 for read/write, T4 for fetch). This allows back-to-back cycles with no idle state between them.
- On acceptance, addr, wdata and mc_type are latched and the next state is T1.
- T1: ale=1; ad_oe=1 with ad_out=addr[7:0]; a_hi=addr[15:8]; iom_n and s1/s0 driven per type.
- Status encoding: FETCH s1s0=11; MEM_RD and IO_RD = 10; MEM_WR and IO_WR = 01.
- Status, iom_n and a_hi hold from T1 until the next cycle's T1. After an idle period they retain their last values.
- T2: ale=0.
  - Read/fetch: ad_oe=0 and rd_n=0.
  - Write: ad_oe=1, ad_out=wdata, wr_n=0.
- READY handling: ready is sampled in T2 and in every TW. If 0, the next state is TW; if 1, the next state is T3.
- TW: all outputs hold their T2 values. A wait counter increments in each TW.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with ready still 0, the cycle aborts: bus_err=1 for one cycle, next state IDLE, strobes high, no done pulse.
- T3: strobes stay low.
  - Read/fetch: rdata <= ad_in at the clock edge that ends T3.
  - At the end of T3 rd_n/wr_n return to 1 and, for writes, ad_oe goes to 0.
  - Read/write: done=1 during T3.
  - Fetch: next state T4.
- T4 (fetch only): bus idle (ad_oe=0, strobes high, ale=0); done=1. rdata becomes valid from T4 onward.
- Latency with no waits: read/write takes 3 cycles (T1..T3); fetch takes 4 cycles. Each TW adds 1 cycle.
- Reserved mc_type codes are ignored: the request is not accepted and the unit stays in IDLE.
- rd_n and wr_n are never low in the same cycle.

Decomposition:
- bus_pkg:
  - mc_type enum: FETCH=3'b000, MEM_RD=001, MEM_WR=010, IO_RD=011, IO_WR=100, others reserved.
  - T-state enum.
  - Status constants.
- No sub-module. The wait counter is inline; its width is $clog2(MAX_WAIT+1), minimum 1.

Test Plan:
- FETCH addr=16'h1234, ready=1, ad_in=8'h7E in T3 -> T1: ale=1, ad_out=34, a_hi=12, s1s0=11. rd_n low T2–T3. rdata=7E. done in T4 (cycle 4).
- MEM_WR addr=16'h2000, wdata=8'hA5, ready=1 -> wr_n low T2–T3, ad_out=A5 with ad_oe=1 in T2–T3, s1s0=01, iom_n=0, done in cycle 3.
- IO_RD, ready=0 for 2 samples -> two TW states with rd_n held low, iom_n=1, done in cycle 5, rdata=ad_in sampled at end of T3.
- MAX_WAIT=3, MEM_RD with ready stuck 0 -> bus_err pulse after the 3rd TW, rd_n=1 next cycle, no done, req_rdy=1.
- Back-to-back: req held high with MEM_RD then MEM_WR -> second T1 immediately follows first T3 with no IDLE; ale pulses in cycles 1 and 4.
- reset asserted during TW of a write -> next cycle wr_n=1, ad_oe=0, state IDLE, no done pulse.
